// File: rtl/fpga_mmcm_reconfig.sv
// MMCME2_ADV runtime reconfiguration: table-driven DRP read-modify-write with MMCM held in reset,
// then release and wait for LOCKED. One DRP access outstanding at a time; requests ignored while busy.
module fpga_mmcm_reconfig #(
  parameter int NUM_CFG      = 2,
  parameter int NUM_WR       = 23,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int DRDY_TIMEOUT = 64,
  localparam int TBL_AW      = $clog2(NUM_CFG * NUM_WR),
  // One spare code so an out-of-range selection can be presented and rejected.
  localparam int SEL_W       = $clog2(NUM_CFG + 1)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cfg_req,
  input  logic [SEL_W-1:0]  cfg_sel,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              locked,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [38:0]       tbl_data,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [6:0]        drp_daddr,
  output logic [15:0]       drp_di,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  output logic              mmcm_rst,
  input  logic              mmcm_locked
);

  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int TMAX  = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int TMR_W = $clog2(TMAX + 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RST  = 4'd1;
  localparam logic [3:0] S_TBL  = 4'd2;
  localparam logic [3:0] S_RD   = 4'd3;
  localparam logic [3:0] S_WRD  = 4'd4;
  localparam logic [3:0] S_WR   = 4'd5;
  localparam logic [3:0] S_WWR  = 4'd6;
  localparam logic [3:0] S_LOCK = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [38:0]      tbl_q, tbl_d;
  logic [15:0]      di_q, di_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lock_s1_q, lock_s2_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    di_d    = di_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The cycle carrying a done/err pulse still counts as the end of the previous job.
        if (cfg_req && !done_q && !err_q) begin
          if (cfg_sel >= SEL_W'(NUM_CFG)) begin
            err_d = 1'b1;
          end else begin
            sel_d   = cfg_sel;
            idx_d   = '0;
            state_d = S_RST;
          end
        end
      end
      S_RST: state_d = S_TBL;
      S_TBL: begin
        tbl_d   = tbl_data;
        state_d = S_RD;
      end
      S_RD: state_d = S_WRD;
      S_WRD: begin
        if (drp_drdy) begin
          di_d    = (drp_do & tbl_q[31:16]) | (tbl_q[15:0] & ~tbl_q[31:16]);
          state_d = S_WR;
        end else if (timer_q == TMR_W'(DRDY_TIMEOUT - 2)) begin
          state_d = S_ERR;
        end
      end
      S_WR: state_d = S_WWR;
      S_WWR: begin
        if (drp_drdy) begin
          if (idx_q == IDX_W'(NUM_WR - 1)) begin
            state_d = S_LOCK;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RST;
          end
        end else if (timer_q == TMR_W'(DRDY_TIMEOUT - 2)) begin
          state_d = S_ERR;
        end
      end
      S_LOCK: begin
        if (lock_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Timer counts cycles spent in the current state; WRD/WWR timeouts then land DRDY_TIMEOUT after drp_den.
    timer_d = (state_d != state_q || state_q == S_IDLE) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      tbl_q     <= '0;
      di_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      tbl_q     <= tbl_d;
      di_q      <= di_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lock_s1_q <= mmcm_locked;
      lock_s2_q <= lock_s1_q;
    end
  end

  assign cfg_busy  = (state_q != S_IDLE) && (state_q != S_ERR);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q || (state_q == S_ERR);
  assign locked    = lock_s2_q;
  assign tbl_addr  = TBL_AW'(int'(sel_q) * NUM_WR + int'(idx_q));
  assign drp_den   = (state_q == S_RD) || (state_q == S_WR);
  assign drp_dwe   = (state_q == S_WR);
  assign drp_daddr = tbl_q[38:32];
  assign drp_di    = di_q;
  assign mmcm_rst  = (state_q == S_RST) || (state_q == S_TBL) || (state_q == S_RD) ||
                     (state_q == S_WRD) || (state_q == S_WR)  || (state_q == S_WWR);

endmodule

// File: tb/tb_fpga_mmcm_reconfig.sv
// Directed bench for fpga_mmcm_reconfig with a table ROM, a 2-cycle DRP model and an MMCM lock model.
module tb_fpga_mmcm_reconfig;

  localparam int NC = 2;
  localparam int NW = 3;
  localparam int LT = 200;
  localparam int DT = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        cfg_req = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic        cfg_busy, cfg_done, cfg_err, locked;
  logic [2:0]  tbl_addr;
  logic [38:0] tbl_data = '0;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b0;

  int total = 0;
  int bad = 0;

  fpga_mmcm_reconfig #(
    .NUM_CFG(NC), .NUM_WR(NW), .LOCK_TIMEOUT(LT), .DRDY_TIMEOUT(DT)
  ) dut (
    .clk(clk), .arst(arst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .locked(locked),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  // Table ROM: {drp_addr, mask, data}, registered read.
  logic [38:0] rom [0:7] = '{
    {7'h08, 16'h0000, 16'h1111},
    {7'h09, 16'hFFFF, 16'h2222},
    {7'h0A, 16'h00FF, 16'h3333},
    {7'h0B, 16'hFF00, 16'h1234},
    {7'h0C, 16'h0F0F, 16'h5678},
    {7'h0D, 16'h0000, 16'h9ABC},
    39'd0, 39'd0
  };
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // DRP model: drdy two cycles after drp_den, logs every access.
  logic [15:0] dmem [0:127] = '{default: 16'hABCD};
  logic        drp_hang = 1'b0;
  logic        pend = 1'b0;
  logic        pwe = 1'b0;
  logic [6:0]  pa = '0;
  logic [15:0] pdi = '0;
  logic [6:0]  log_a  [0:63];
  logic        log_we [0:63];
  logic [15:0] log_di [0:63];
  logic [2:0]  log_ta [0:63];
  int          log_n = 0;

  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (pend) begin
      pend     <= 1'b0;
      drp_drdy <= 1'b1;
      drp_do   <= dmem[pa];
      if (pwe) dmem[pa] <= pdi;
    end
    if (drp_den && !drp_hang) begin
      pend <= 1'b1;
      pa   <= drp_daddr;
      pwe  <= drp_dwe;
      pdi  <= drp_di;
    end
    if (drp_den && log_n < 64) begin
      log_a[log_n]  <= drp_daddr;
      log_we[log_n] <= drp_dwe;
      log_di[log_n] <= drp_di;
      log_ta[log_n] <= tbl_addr;
      log_n         <= log_n + 1;
    end
  end

  // MMCM model: LOCKED rises 10 cycles after RST is released.
  logic lock_hold = 1'b0;
  int   lock_cnt = 0;
  always @(posedge clk) begin
    if (mmcm_rst || lock_hold) begin
      lock_cnt    <= 0;
      mmcm_locked <= 1'b0;
    end else if (lock_cnt == 9) begin
      mmcm_locked <= 1'b1;
    end else begin
      lock_cnt <= lock_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] s);
    cfg_sel = s;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    #2 arst = 1'b1;
    tick();
    outs = {cfg_busy, cfg_done, cfg_err, locked, tbl_addr, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    arst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_main();
    int base, rst_hi, k;
    logic [6:0]  ea [0:5] = '{7'h0B, 7'h0B, 7'h0C, 7'h0C, 7'h0D, 7'h0D};
    logic [15:0] ed [0:5] = '{16'h0, 16'hAB34, 16'h0, 16'h5B7D, 16'h0, 16'h9ABC};
    logic [2:0]  et [0:5] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5};
    base = log_n;
    req(2'd1);
    total++;
    if (!(cfg_busy === 1'b1 && mmcm_rst === 1'b1)) begin
      bad++;
      $display("FAIL main_start busy=%b rst=%b want 1 1", cfg_busy, mmcm_rst);
    end
    rst_hi = 1;
    while (mmcm_rst === 1'b1 && rst_hi < 200) begin
      tick();
      if (mmcm_rst === 1'b1) rst_hi++;
    end
    total++;
    if (rst_hi != 24) begin
      bad++;
      $display("FAIL main_rst_cycles got=%0d want=24", rst_hi);
    end
    k = 0;
    while (cfg_done !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    total++;
    if (k != 13 || cfg_busy !== 1'b0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL main_done_latency got=%0d busy=%b locked=%b want 13 0 1", k, cfg_busy, locked);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (log_a[base+i] !== ea[i] || log_we[base+i] !== i[0] || log_ta[base+i] !== et[i] ||
          (i[0] && log_di[base+i] !== ed[i])) begin
        bad++;
        $display("FAIL main_access%0d got a=%h we=%b di=%h ta=%0d want a=%h we=%b di=%h ta=%0d",
                 i, log_a[base+i], log_we[base+i], log_di[base+i], log_ta[base+i],
                 ea[i], i[0], ed[i], et[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, k;
    logic [15:0] ed [0:2] = '{16'h1111, 16'hABCD, 16'h33CD};
    // Request raised in the done cycle must be dropped.
    cfg_sel = 2'd0;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    total++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop busy=%b done=%b want 0 0", cfg_busy, cfg_done);
    end
    base = log_n;
    req(2'd0);
    total++;
    if (cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept busy=%b want 1", cfg_busy);
    end
    k = 0;
    while (cfg_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (cfg_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done timeout");
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (log_di[base+2*i+1] !== ed[i] || log_a[base+2*i+1] !== 7'(8 + i)) begin
        bad++;
        $display("FAIL b2b_write%0d got a=%h di=%h want a=%h di=%h",
                 i, log_a[base+2*i+1], log_di[base+2*i+1], 7'(8 + i), ed[i]);
      end
    end
    tick();
  endtask

  task automatic test_bad_sel();
    int base;
    base = log_n;
    cfg_sel = 2'd2;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || cfg_busy !== 1'b0 || mmcm_rst !== 1'b0) begin
      bad++;
      $display("FAIL badsel_pulse err=%b busy=%b rst=%b want 1 0 0", cfg_err, cfg_busy, mmcm_rst);
    end
    tick();
    total++;
    if (cfg_err !== 1'b0 || log_n != base || mmcm_rst !== 1'b0) begin
      bad++;
      $display("FAIL badsel_after err=%b accesses=%0d rst=%b want 0 0 0", cfg_err, log_n - base, mmcm_rst);
    end
  endtask

  task automatic test_drdy_timeout();
    int k, n;
    drp_hang = 1'b1;
    req(2'd0);
    k = 0;
    while (drp_den !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n = 0;
    while (cfg_err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n != DT || mmcm_rst !== 1'b0 || cfg_busy !== 1'b0) begin
      bad++;
      $display("FAIL drdy_timeout got=%0d rst=%b busy=%b want %0d 0 0", n, mmcm_rst, cfg_busy, DT);
    end
    drp_hang = 1'b0;
    tick();
    req(2'd0);
    total++;
    if (cfg_busy !== 1'b1) begin
      bad++;
      $display("FAIL drdy_reaccept busy=%b want 1", cfg_busy);
    end
    k = 0;
    while (cfg_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (cfg_done !== 1'b1) begin
      bad++;
      $display("FAIL drdy_recover_done timeout");
    end
    tick();
  endtask

  task automatic test_lock_timeout();
    int rst_hi, n;
    lock_hold = 1'b1;
    req(2'd0);
    rst_hi = 1;
    while (mmcm_rst === 1'b1 && rst_hi < 200) begin
      cfg_req = (rst_hi == 5);
      tick();
      if (mmcm_rst === 1'b1) rst_hi++;
    end
    cfg_req = 1'b0;
    n = 0;
    while (cfg_err !== 1'b1 && n < 400) begin
      cfg_req = (n == 50 || n == 150);
      tick();
      n++;
    end
    cfg_req = 1'b0;
    total++;
    if (n != LT || rst_hi != 24 || cfg_busy !== 1'b0) begin
      bad++;
      $display("FAIL lock_timeout got=%0d rst_cycles=%0d busy=%b want %0d 24 0", n, rst_hi, cfg_busy, LT);
    end
    lock_hold = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (cfg_busy !== 1'b0 || mmcm_rst !== 1'b0) begin
      bad++;
      $display("FAIL lock_no_queue busy=%b rst=%b want 0 0", cfg_busy, mmcm_rst);
    end
  endtask

  task automatic test_arst_wwr();
    int k;
    logic [34:0] outs;
    req(2'd1);
    k = 0;
    while (drp_dwe !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tick();
    arst = 1'b1;
    #1;
    outs = {cfg_busy, cfg_done, cfg_err, locked, tbl_addr, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL arst_outputs got=%h want=0", outs);
    end
    tick();
    outs = {cfg_busy, cfg_done, cfg_err, locked, tbl_addr, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL arst_hold got=%h want=0", outs);
    end
    arst = 1'b0;
    tick();
    tick();
    req(2'd1);
    k = 0;
    while (drp_den !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (drp_den !== 1'b1 || drp_dwe !== 1'b0 || drp_daddr !== 7'h0B || tbl_addr !== 3'd3) begin
      bad++;
      $display("FAIL arst_restart den=%b we=%b a=%h ta=%0d want 1 0 0b 3", drp_den, drp_dwe, drp_daddr, tbl_addr);
    end
    k = 0;
    while (cfg_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++;
    if (cfg_done !== 1'b1) begin
      bad++;
      $display("FAIL arst_restart_done timeout");
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_back_to_back();
    test_bad_sel();
    test_drdy_timeout();
    test_lock_timeout();
    test_arst_wwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
